// File: rtl/proc_pkg.sv
// Shared decode constants for the pipeline control blocks: opcode/aluop values,
// instruction field positions, operand-select encoding and mult/div FSM states.
package proc_pkg;

  localparam int OP_LO    = 27;
  localparam int OP_W     = 5;
  localparam int RD_LO    = 22;
  localparam int RS_LO    = 17;
  localparam int RT_LO    = 12;
  localparam int ALUOP_LO = 2;
  localparam int ALUOP_W  = 5;

  typedef logic [OP_W-1:0]    opcode_t;
  typedef logic [ALUOP_W-1:0] aluOp_t;
  typedef logic [1:0]         fwdSel_t;

  localparam opcode_t OP_ALU  = 5'd0;
  localparam opcode_t OP_BNE  = 5'd2;
  localparam opcode_t OP_JAL  = 5'd3;
  localparam opcode_t OP_ADDI = 5'd5;
  localparam opcode_t OP_BLT  = 5'd6;
  localparam opcode_t OP_SW   = 5'd7;
  localparam opcode_t OP_LW   = 5'd8;

  localparam aluOp_t ALUOP_MUL = 5'd6;
  localparam aluOp_t ALUOP_DIV = 5'd7;

  // Operand source encoding; value 3 is reserved and never produced.
  localparam fwdSel_t SEL_REG = 2'd0;
  localparam fwdSel_t SEL_XM  = 2'd1;
  localparam fwdSel_t SEL_MW  = 2'd2;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_BUSY = 2'd1;
  localparam logic [1:0] MD_DONE = 2'd2;

  function automatic logic isMulDiv(input opcode_t op, input aluOp_t aluOp);
    return (op == OP_ALU) && ((aluOp == ALUOP_MUL) || (aluOp == ALUOP_DIV));
  endfunction

endpackage

// File: rtl/md_sequencer.sv
// Mult/div launch sequencer: pulses start, holds the pipeline while the unit
// is busy, and releases it for one DONE cycle before accepting a new operation.
module md_sequencer
  import proc_pkg::*;
#(
  parameter int MD_LAT = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic mdOp,
  input  logic mdReady,
  output logic mdStart,
  output logic mdBusy,
  output logic mdStall
);

  localparam int CNT_W = (MD_LAT > 0) ? $clog2(MD_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = (MD_LAT > 0) ? CNT_W'(MD_LAT - 1) : '0;

  logic [1:0]       state;
  logic [CNT_W-1:0] count;

  // With MD_LAT=0 completion comes from mdReady; otherwise from the down-counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= MD_IDLE;
      count <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (mdOp) begin
            state <= MD_BUSY;
            count <= LOAD_VAL;
          end
        end
        MD_BUSY: begin
          if (MD_LAT == 0) begin
            if (mdReady) state <= MD_DONE;
          end else if (count == '0) begin
            state <= MD_DONE;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        MD_DONE: state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign mdStart = (state == MD_IDLE) && mdOp && !reset;
  assign mdBusy  = (state == MD_BUSY);
  assign mdStall = mdStart | mdBusy;

endmodule

// File: rtl/bypass_hazard_unit.sv
// Pipeline bypass and hazard control: picks ALU/store operand sources from the
// XM/MW latches, detects load-use hazards and sequences mult/div stalls.
module bypass_hazard_unit
  import proc_pkg::*;
#(
  parameter int IR_W   = 32,
  parameter int REG_W  = 5,
  parameter int MD_LAT = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [IR_W-1:0] fd_ir,
  input  logic [IR_W-1:0] dx_ir,
  input  logic [IR_W-1:0] xm_ir,
  input  logic [IR_W-1:0] mw_ir,
  input  logic            md_ready,
  output logic [1:0]      a_sel,
  output logic [1:0]      b_sel,
  output logic            mem_sel,
  output logic            stall,
  output logic            md_start,
  output logic            md_busy
);

  typedef logic [REG_W-1:0] regId_t;

  function automatic opcode_t opOf(input logic [IR_W-1:0] ir);
    return ir[OP_LO +: OP_W];
  endfunction

  function automatic aluOp_t aluOpOf(input logic [IR_W-1:0] ir);
    return ir[ALUOP_LO +: ALUOP_W];
  endfunction

  function automatic regId_t rdOf(input logic [IR_W-1:0] ir);
    return ir[RD_LO +: REG_W];
  endfunction

  function automatic regId_t rsOf(input logic [IR_W-1:0] ir);
    return ir[RS_LO +: REG_W];
  endfunction

  function automatic regId_t rtOf(input logic [IR_W-1:0] ir);
    return ir[RT_LO +: REG_W];
  endfunction

  // Register 0 doubles as "no destination" / "no source", so it never matches.
  function automatic regId_t destOf(input logic [IR_W-1:0] ir);
    regId_t r;
    case (opOf(ir))
      OP_ALU, OP_ADDI, OP_LW: r = rdOf(ir);
      OP_JAL:                 r = '1;
      default:                r = '0;
    endcase
    return r;
  endfunction

  function automatic regId_t srcAOf(input logic [IR_W-1:0] ir);
    regId_t r;
    case (opOf(ir))
      OP_ALU, OP_ADDI, OP_LW, OP_SW: r = rsOf(ir);
      OP_BNE, OP_BLT:                r = rdOf(ir);
      default:                       r = '0;
    endcase
    return r;
  endfunction

  function automatic regId_t srcBOf(input logic [IR_W-1:0] ir);
    regId_t r;
    case (opOf(ir))
      OP_ALU:         r = rtOf(ir);
      OP_SW:          r = rdOf(ir);
      OP_BNE, OP_BLT: r = rsOf(ir);
      default:        r = '0;
    endcase
    return r;
  endfunction

  regId_t xmDest;
  regId_t mwDest;
  regId_t dxLoadDest;
  logic   loadUse;
  logic   mdOp;
  logic   mdStall;
  logic   unusedIrBits;

  function automatic fwdSel_t fwdSelFor(input regId_t src, input regId_t xmD, input regId_t mwD);
    fwdSel_t s;
    if (src != '0 && src == xmD)      s = SEL_XM;
    else if (src != '0 && src == mwD) s = SEL_MW;
    else                              s = SEL_REG;
    return s;
  endfunction

  assign xmDest = destOf(xm_ir);
  assign mwDest = destOf(mw_ir);

  assign a_sel = fwdSelFor(srcAOf(dx_ir), xmDest, mwDest);
  assign b_sel = fwdSelFor(srcBOf(dx_ir), xmDest, mwDest);

  assign mem_sel = (opOf(xm_ir) == OP_SW) && (opOf(mw_ir) == OP_LW) &&
                   (rdOf(xm_ir) == rdOf(mw_ir)) && (rdOf(xm_ir) != '0);

  // Store data from a load is bypassed via mem_sel, so sw's rd is not a hazard.
  assign dxLoadDest = (opOf(dx_ir) == OP_LW) ? rdOf(dx_ir) : '0;
  assign loadUse = (dxLoadDest != '0) &&
                   ((srcAOf(fd_ir) == dxLoadDest) ||
                    ((opOf(fd_ir) != OP_SW) && (srcBOf(fd_ir) == dxLoadDest)));

  assign mdOp = isMulDiv(opOf(dx_ir), aluOpOf(dx_ir));

  md_sequencer #(
    .MD_LAT (MD_LAT)
  ) mdSeq (
    .clock   (clock),
    .reset   (reset),
    .mdOp    (mdOp),
    .mdReady (md_ready),
    .mdStart (md_start),
    .mdBusy  (md_busy),
    .mdStall (mdStall)
  );

  assign stall = loadUse | mdStall;

  assign unusedIrBits = ^{fd_ir, dx_ir, xm_ir, mw_ir};

endmodule

// File: tb/tb_bypass_hazard_unit.sv
// Bench for bypass_hazard_unit: two instances (MD_LAT=0 and MD_LAT=4) checked
// every cycle against a timestamp-based reference model, plus directed cases.
module tb_bypass_hazard_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] fdIr, dxIr, xmIr, mwIr;
  logic        mdReady;

  logic [1:0] aSel0, bSel0, aSel4, bSel4;
  logic       memSel0, memSel4, stall0, stall4;
  logic       mdStart0, mdStart4, mdBusy0, mdBusy4;

  int checks = 0;
  int passes = 0;
  bit cmpEn = 1'b0;

  always #5 clock = ~clock;

  bypass_hazard_unit #(.IR_W(32), .REG_W(5), .MD_LAT(0)) dut0 (
    .clock(clock), .reset(reset), .fd_ir(fdIr), .dx_ir(dxIr), .xm_ir(xmIr), .mw_ir(mwIr),
    .md_ready(mdReady), .a_sel(aSel0), .b_sel(bSel0), .mem_sel(memSel0), .stall(stall0),
    .md_start(mdStart0), .md_busy(mdBusy0));

  bypass_hazard_unit #(.IR_W(32), .REG_W(5), .MD_LAT(4)) dut4 (
    .clock(clock), .reset(reset), .fd_ir(fdIr), .dx_ir(dxIr), .xm_ir(xmIr), .mw_ir(mwIr),
    .md_ready(mdReady), .a_sel(aSel4), .b_sel(bSel4), .mem_sel(memSel4), .stall(stall4),
    .md_start(mdStart4), .md_busy(mdBusy4));

  function automatic logic [31:0] mkIr(input int op, input int rd, input int rs, input int rt, input int alu);
    return {5'(op), 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(alu), 2'd0};
  endfunction

  function automatic int fOp(input logic [31:0] ir);  return int'(ir[31:27]); endfunction
  function automatic int fRd(input logic [31:0] ir);  return int'(ir[26:22]); endfunction
  function automatic int fRs(input logic [31:0] ir);  return int'(ir[21:17]); endfunction
  function automatic int fRt(input logic [31:0] ir);  return int'(ir[16:12]); endfunction
  function automatic int fAlu(input logic [31:0] ir); return int'(ir[6:2]);   endfunction

  // Reference rules; 0 means "no register" and never matches anything.
  function automatic int destReg(input logic [31:0] ir);
    int op = fOp(ir);
    if (op == 0 || op == 5 || op == 8) return fRd(ir);
    if (op == 3) return 31;
    return 0;
  endfunction

  function automatic int readA(input logic [31:0] ir);
    int op = fOp(ir);
    if (op == 0 || op == 5 || op == 8 || op == 7) return fRs(ir);
    if (op == 2 || op == 6) return fRd(ir);
    return 0;
  endfunction

  function automatic int readB(input logic [31:0] ir);
    int op = fOp(ir);
    if (op == 0) return fRt(ir);
    if (op == 7) return fRd(ir);
    if (op == 2 || op == 6) return fRs(ir);
    return 0;
  endfunction

  function automatic int expSel(input int src);
    if (src == 0) return 0;
    if (destReg(xmIr) == src) return 1;
    if (destReg(mwIr) == src) return 2;
    return 0;
  endfunction

  function automatic int expMemSel();
    return (fOp(xmIr) == 7 && fOp(mwIr) == 8 && fRd(xmIr) == fRd(mwIr) && fRd(xmIr) != 0) ? 1 : 0;
  endfunction

  function automatic int expLoadUse();
    int d;
    if (fOp(dxIr) != 8 || fRd(dxIr) == 0) return 0;
    d = fRd(dxIr);
    if (readA(fdIr) == d) return 1;
    if (fOp(fdIr) != 7 && readB(fdIr) == d) return 1;
    return 0;
  endfunction

  function automatic bit dxIsMd();
    return fOp(dxIr) == 0 && (fAlu(dxIr) == 6 || fAlu(dxIr) == 7);
  endfunction

  // Mult/div model as timestamps: when the op was launched and when DONE falls.
  localparam int NEVER = 1 << 30;
  int lat[2] = '{0, 4};
  bit active[2];
  int startCyc[2];
  int doneCyc[2];
  int cyc = 0;

  function automatic int expStart(input int i);
    return (!reset && !active[i] && dxIsMd()) ? 1 : 0;
  endfunction

  function automatic int expBusy(input int i);
    return (active[i] && cyc > startCyc[i] && cyc < doneCyc[i]) ? 1 : 0;
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        active[i] = 1'b0;
      end else if (!active[i]) begin
        if (dxIsMd()) begin
          active[i]   = 1'b1;
          startCyc[i] = cyc;
          doneCyc[i]  = (lat[i] > 0) ? cyc + lat[i] + 1 : NEVER;
        end
      end else if (cyc == doneCyc[i]) begin
        active[i] = 1'b0;
      end else if (lat[i] == 0 && cyc > startCyc[i] && mdReady) begin
        doneCyc[i] = cyc + 1;
      end
    end
    cyc++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  always @(negedge clock) begin
    if (cmpEn) begin
      checkOutput("a_sel lat0", int'(aSel0), expSel(readA(dxIr)));
      checkOutput("b_sel lat0", int'(bSel0), expSel(readB(dxIr)));
      checkOutput("a_sel lat4", int'(aSel4), expSel(readA(dxIr)));
      checkOutput("b_sel lat4", int'(bSel4), expSel(readB(dxIr)));
      checkOutput("mem_sel lat0", int'(memSel0), expMemSel());
      checkOutput("mem_sel lat4", int'(memSel4), expMemSel());
      checkOutput("md_start lat0", int'(mdStart0), expStart(0));
      checkOutput("md_start lat4", int'(mdStart4), expStart(1));
      checkOutput("md_busy lat0", int'(mdBusy0), expBusy(0));
      checkOutput("md_busy lat4", int'(mdBusy4), expBusy(1));
      checkOutput("stall lat0", int'(stall0), expLoadUse() | expStart(0) | expBusy(0));
      checkOutput("stall lat4", int'(stall4), expLoadUse() | expStart(1) | expBusy(1));
    end
  end

  task automatic applyStimulus(input logic rst, input logic [31:0] fd, input logic [31:0] dx,
                               input logic [31:0] xm, input logic [31:0] mw, input logic rdy);
    @(posedge clock);
    #1;
    reset = rst; fdIr = fd; dxIr = dx; xmIr = xm; mwIr = mw; mdReady = rdy;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, '0, '0, '0, '0, 1'b0);
  endtask

  function automatic int randReg();
    return ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] randIr();
    int ops[12] = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 8};
    return mkIr(ops[$urandom_range(0, 11)], randReg(), randReg(), randReg(), int'($urandom_range(0, 7)));
  endfunction

  logic [31:0] addR3, addR4r3r3, lwR3, addR4r3, addR0, lwR5, addiR6, swR5, mulOp, divOp;
  int stallCnt, startCnt, busyCnt, doneStall;

  initial begin
    addR3     = mkIr(0, 3, 1, 2, 0);
    addR4r3r3 = mkIr(0, 4, 3, 3, 0);
    lwR3      = mkIr(8, 3, 1, 0, 0);
    addR4r3   = mkIr(0, 4, 3, 0, 0);
    addR0     = mkIr(0, 0, 1, 2, 0);
    lwR5      = mkIr(8, 5, 2, 0, 0);
    addiR6    = mkIr(5, 6, 5, 0, 0) | 32'd1;
    swR5      = mkIr(7, 5, 2, 0, 0);
    mulOp     = mkIr(0, 7, 1, 2, 6);
    divOp     = mkIr(0, 7, 1, 2, 7);

    reset = 1'b1; fdIr = '0; dxIr = '0; xmIr = '0; mwIr = '0; mdReady = 1'b0;
    @(posedge clock);
    #1;
    cmpEn = 1'b1;
    @(negedge clock);
    checkOutput("reset md_busy", int'(mdBusy4), 0);
    checkOutput("reset md_start", int'(mdStart4), 0);

    applyStimulus(1'b0, '0, addR4r3r3, addR3, '0, 1'b0);
    @(negedge clock);
    checkOutput("xm fwd a_sel", int'(aSel0), 1);
    checkOutput("xm fwd b_sel", int'(bSel0), 1);

    applyStimulus(1'b0, '0, addR4r3, addR3, lwR3, 1'b0);
    @(negedge clock);
    checkOutput("xm priority a_sel", int'(aSel0), 1);
    applyStimulus(1'b0, '0, addR4r3, addR0, lwR3, 1'b0);
    @(negedge clock);
    checkOutput("mw fwd a_sel", int'(aSel0), 2);
    checkOutput("r0 src b_sel", int'(bSel0), 0);

    applyStimulus(1'b0, addiR6, lwR5, '0, '0, 1'b0);
    @(negedge clock);
    checkOutput("load-use stall", int'(stall0), 1);
    applyStimulus(1'b0, addiR6, '0, lwR5, '0, 1'b0);
    @(negedge clock);
    checkOutput("load-use one cycle", int'(stall0), 0);
    applyStimulus(1'b0, swR5, lwR5, '0, '0, 1'b0);
    @(negedge clock);
    checkOutput("sw data no stall", int'(stall0), 0);
    applyStimulus(1'b0, '0, '0, swR5, lwR5, 1'b0);
    @(negedge clock);
    checkOutput("mem_sel", int'(memSel0), 1);

    doReset();
    stallCnt = 0; startCnt = 0; doneStall = 1;
    for (int k = 0; k <= 8; k++) begin
      applyStimulus(1'b0, '0, mulOp, '0, '0, (k == 7));
      @(negedge clock);
      if (stall0) stallCnt++;
      if (mdStart0) startCnt++;
      if (k == 8) doneStall = int'(stall0);
    end
    checkOutput("mul stall cycles", stallCnt, 8);
    checkOutput("mul start pulses", startCnt, 1);
    checkOutput("mul done stall", doneStall, 0);

    doReset();
    busyCnt = 0; startCnt = 0;
    for (int k = 0; k <= 7; k++) begin
      applyStimulus(1'b0, '0, (k <= 5) ? divOp : 32'd0, '0, '0, 1'b1);
      @(negedge clock);
      if (mdBusy4) busyCnt++;
      if (mdStart4) startCnt++;
    end
    checkOutput("div busy cycles", busyCnt, 4);
    checkOutput("div start pulses", startCnt, 1);

    doReset();
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, '0, mulOp, '0, '0, 1'b0);
    applyStimulus(1'b1, '0, '0, '0, '0, 1'b0);
    busyCnt = 0; stallCnt = 0; startCnt = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, '0, '0, '0, '0, 1'b0);
      @(negedge clock);
      busyCnt  += int'(mdBusy0) + int'(mdBusy4);
      stallCnt += int'(stall0) + int'(stall4);
      startCnt += int'(mdStart0) + int'(mdStart4);
    end
    checkOutput("abort md_busy", busyCnt, 0);
    checkOutput("abort stall", stallCnt, 0);
    checkOutput("abort md_start", startCnt, 0);

    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 49) == 0), randIr(), randIr(), randIr(), randIr(),
                    ($urandom_range(0, 3) == 0));
    end
    @(negedge clock);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bypass_hazard_unit.md
BYPASS_HAZARD_UNIT -- requirements
Module: bypass_hazard_unit

Interface
REQ-001 SHALL have parameter IR_W, default 32: instruction width.
REQ-002 SHALL have parameter REG_W, default 5: register-specifier width.
REQ-003 SHALL have parameter MD_LAT, default 0: 0 means wait for md_ready; N>0 means the mult/div unit completes N cycles after start.
REQ-004 SHALL have the port clock, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have the port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 SHALL have the ports fd_ir, dx_ir, xm_ir, mw_ir, input, IR_W each: instructions in the FD, DX, XM and MW latches.
REQ-007 SHALL have the port md_ready, input, 1 bit: mult/div result valid, used only when MD_LAT=0.
REQ-008 SHALL have the ports a_sel, b_sel, output, 2 bits each: ALU operand source (0 regfile, 1 XM result, 2 MW writeback; 3 never driven).
REQ-009 SHALL have the port mem_sel, output, 1 bit: store data taken from MW writeback.
REQ-010 SHALL have the port stall, output, 1 bit: hold PC/FD/DX and insert a nop into XM.
REQ-011 SHALL have the port md_start, output, 1 bit: single-cycle mult/div launch.
REQ-012 SHALL have the port md_busy, output, 1 bit: mult/div in flight.

Function
REQ-013 SHALL decode fields as: op [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2]; ops ALU=0, bne=2, jal=3, addi=5, blt=6, sw=7, lw=8; mul/div = op 0 with aluop 6 or 7.
REQ-014 SHALL treat a stage as a writer when op is 0, 5 or 8 (dest rd) or op is 3 (dest r31).
REQ-015 SHALL never forward or stall on destination register 0.
REQ-016 SHALL select operand A sources: rs for ALU/addi/lw/sw; rd for bne/blt.
REQ-017 SHALL select operand B sources: rt for ALU; rd for sw; rs for bne/blt; none for others (b_sel=0).
REQ-018 SHALL drive a_sel/b_sel to 1 if XM writes a matching destination, else 2 if MW does, else 0 (XM priority), combinationally.
REQ-019 SHALL assert mem_sel when XM is sw, MW is lw, rd fields equal and are nonzero.
REQ-020 SHALL raise load-use stall when DX is lw with rd≠0 and FD reads that register per REQ-016/017 (excluding sw data rd, covered by mem_sel).
REQ-021 SHALL implement the mult/div FSM with states IDLE, BUSY, DONE.
REQ-022 SHALL in IDLE, when DX is mul/div, assert md_start and stall for that cycle and go to BUSY next cycle.
REQ-023 SHALL in BUSY assert stall and md_busy.
REQ-024 SHALL with MD_LAT=0 leave BUSY for DONE on md_ready=1, ignoring md_ready outside BUSY.
REQ-025 SHALL with MD_LAT=N load the down-counter with N-1 on md_start, decrement it in BUSY, and go to DONE when BUSY sees count 0.
REQ-026 SHALL in DONE deassert stall (unless load-use), never assert md_start, and return to IDLE next cycle.
REQ-027 SHALL drive stall = load-use OR mult/div stall.
REQ-028 SHALL let forwarding outputs remain valid during stall.
REQ-029 SHALL size the counter ceil(log2(MD_LAT+1)) bits, minimum 1.

Reset
REQ-030 SHALL on reset (synchronous, active-high) put the FSM in IDLE and clear the counter to 0.
REQ-031 SHALL have md_start=0, md_busy=0 and the FSM contribution to stall 0 in the cycle after reset.
REQ-032 SHALL let reset asserted mid-BUSY abandon the operation, with no md_start until a new mul/div is seen in DX.

Structure
REQ-033 SHALL place opcode/aluop constants, field bit positions and the a_sel/b_sel encoding in shared package proc_pkg.
REQ-034 SHALL have one sub-module, md_sequencer (FSM plus counter); forwarding and load-use logic stay in the top.

Verification
REQ-035 SHALL check: XM=add r3, DX=add r4,r3,r3 -> a_sel=1, b_sel=1.
REQ-036 SHALL check: XM=add r3 and MW=lw r3, DX reads r3 -> a_sel=1; change XM dest to r0 -> a_sel=2.
REQ-037 SHALL check: DX=lw r5, FD=addi r6,r5,1 -> stall=1 for exactly one cycle; FD=sw r5,0(r2) -> stall=0.
REQ-038 SHALL check: MD_LAT=0, DX=mul; md_ready raised 7 cycles after md_start -> stall high 8 cycles, one md_start pulse, DONE cycle stall=0.
REQ-039 SHALL check: MD_LAT=4, DX=div -> md_busy high exactly 4 cycles, md_ready ignored.
REQ-040 SHALL check: reset asserted 2 cycles into BUSY, DX=nop afterwards -> md_busy=0, stall=0, no md_start.
